// File: rtl/step_delay_pkg.sv
// Shared types and constants for the step/delay unit.
// HALF_STEP_EN selects the 8-entry half-step phase table instead of the 4-entry full-step one.
package step_delay_pkg;

    localparam int TEMP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } delay_state_t;

    localparam int FULL_STEP_LEN = 4;
    localparam int HALF_STEP_LEN = 8;

    // Index 0 is the leftmost entry, which is also the post-reset pattern.
    localparam logic [0:FULL_STEP_LEN-1][3:0] FULL_STEP_TABLE = {
        4'b1100, 4'b0110, 4'b0011, 4'b1001
    };

    localparam logic [0:HALF_STEP_LEN-1][3:0] HALF_STEP_TABLE = {
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

`ifdef HALF_STEP_EN
    localparam int PHASE_LEN = HALF_STEP_LEN;
`else
    localparam int PHASE_LEN = FULL_STEP_LEN;
`endif

    localparam int PHASE_IDX_W = $clog2(PHASE_LEN);

endpackage

// File: rtl/step_delay_timer.sv
// Delay FSM with prescaler: counts delay_value ticks of PRESCALE clk cycles each,
// then holds delay_done until the next start or reset.
module step_delay_timer
    import step_delay_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DELAY_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_delay_counter,
    input  logic               enable_delay_counter,
    input  logic [DELAY_W-1:0] delay_value,
    output logic               delay_done
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    delay_state_t       state_q;
    delay_state_t       state_d;
    logic [DELAY_W-1:0] count_q;
    logic [PRE_W-1:0]   pre_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start pulse wins from any state, so a start during COUNT restarts the delay.
    always_comb begin
        state_d = state_q;
        if (start_delay_counter) begin
            state_d = COUNT;
        end else begin
            case (state_q)
                COUNT:   if (count_q == '0) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        delay_done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            pre_q   <= '0;
        end else if (start_delay_counter) begin
            count_q <= delay_value;
            pre_q   <= '0;
        end else if (state_q == COUNT && enable_delay_counter && count_q != '0) begin
            if (pre_q == PRE_LAST) begin
                pre_q   <= '0;
                count_q <= count_q - DELAY_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_delay_unit.sv
// Signed temp register driving a stepper phase walker, plus the delay timer.
// Build with HALF_STEP_EN defined for the half-step phase table.
module step_delay_unit
    import step_delay_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DELAY_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_temp_register,
    input  logic                     increment_temp_register,
    input  logic                     decrement_temp_register,
    input  logic signed [TEMP_W-1:0] temp_load_value,
    input  logic                     start_delay_counter,
    input  logic                     enable_delay_counter,
    input  logic [DELAY_W-1:0]       delay_value,
    output logic                     temp_is_positive,
    output logic                     temp_is_negative,
    output logic                     temp_is_zero,
    output logic                     delay_done,
    output logic [3:0]               stepper_phase
);

    localparam logic [PHASE_IDX_W-1:0] PHASE_LAST = PHASE_IDX_W'(PHASE_LEN - 1);

    logic signed [TEMP_W-1:0] temp_q;
    logic [PHASE_IDX_W-1:0]   phase_idx_q;
    logic                     do_inc;
    logic                     do_dec;

    // Load masks both steps; inc and dec together cancel into a hold.
    assign do_inc = !load_temp_register && increment_temp_register && !decrement_temp_register;
    assign do_dec = !load_temp_register && decrement_temp_register && !increment_temp_register;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            temp_q <= '0;
        end else if (load_temp_register) begin
            temp_q <= temp_load_value;
        end else if (do_inc) begin
            temp_q <= temp_q + TEMP_W'(1);
        end else if (do_dec) begin
            temp_q <= temp_q - TEMP_W'(1);
        end
    end

    // Decrement steps the motor forward, increment steps it backward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_idx_q <= '0;
        end else if (do_dec) begin
            phase_idx_q <= (phase_idx_q == PHASE_LAST) ? '0 : phase_idx_q + PHASE_IDX_W'(1);
        end else if (do_inc) begin
            phase_idx_q <= (phase_idx_q == '0) ? PHASE_LAST : phase_idx_q - PHASE_IDX_W'(1);
        end
    end

    assign temp_is_zero     = (temp_q == '0);
    assign temp_is_negative = temp_q[TEMP_W-1];
    assign temp_is_positive = !temp_q[TEMP_W-1] && (temp_q != '0);

`ifdef HALF_STEP_EN
    assign stepper_phase = HALF_STEP_TABLE[phase_idx_q];
`else
    assign stepper_phase = FULL_STEP_TABLE[phase_idx_q];
`endif

    step_delay_timer #(
        .PRESCALE (PRESCALE),
        .DELAY_W  (DELAY_W)
    ) u_timer (
        .clk                  (clk),
        .reset_n              (reset_n),
        .start_delay_counter  (start_delay_counter),
        .enable_delay_counter (enable_delay_counter),
        .delay_value          (delay_value),
        .delay_done           (delay_done)
    );

endmodule

// File: tb/tb_step_delay_unit.sv
// Scoreboard bench for step_delay_unit with PRESCALE=4; follows HALF_STEP_EN if defined.
module tb_step_delay_unit;

    localparam int PRESCALE = 4;
    localparam int DELAY_W  = 8;
    localparam int WAIT_MAX = 300;

`ifdef HALF_STEP_EN
    localparam int TBL_LEN = 8;
    localparam logic [3:0] PHASE_TBL [TBL_LEN] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001
    };
`else
    localparam int TBL_LEN = 4;
    localparam logic [3:0] PHASE_TBL [TBL_LEN] = '{
        4'b1100, 4'b0110, 4'b0011, 4'b1001
    };
`endif

    typedef struct {
        string      tag;
        logic [2:0] flags;
        logic [3:0] phase;
    } temp_exp_t;

    logic               clk;
    logic               reset_n;
    logic               load_temp_register;
    logic               increment_temp_register;
    logic               decrement_temp_register;
    logic signed [7:0]  temp_load_value;
    logic               start_delay_counter;
    logic               enable_delay_counter;
    logic [DELAY_W-1:0] delay_value;
    logic               temp_is_positive;
    logic               temp_is_negative;
    logic               temp_is_zero;
    logic               delay_done;
    logic [3:0]         stepper_phase;

    temp_exp_t         temp_sb [$];
    int                done_sb [$];
    logic signed [7:0] m_temp;
    int                m_idx;
    int                total;
    int                bad;

    step_delay_unit #(
        .PRESCALE (PRESCALE),
        .DELAY_W  (DELAY_W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .load_temp_register      (load_temp_register),
        .increment_temp_register (increment_temp_register),
        .decrement_temp_register (decrement_temp_register),
        .temp_load_value         (temp_load_value),
        .start_delay_counter     (start_delay_counter),
        .enable_delay_counter    (enable_delay_counter),
        .delay_value             (delay_value),
        .temp_is_positive        (temp_is_positive),
        .temp_is_negative        (temp_is_negative),
        .temp_is_zero            (temp_is_zero),
        .delay_done              (delay_done),
        .stepper_phase           (stepper_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_flags(input logic signed [7:0] t);
        return {t > 8'sd0, t < 8'sd0, t == 8'sd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one temp command, advance the model, push the expectation, then pop and compare.
    task automatic apply_stimulus(input string tag, input logic ld, input logic inc,
                                  input logic dec, input logic signed [7:0] val);
        temp_exp_t e;
        load_temp_register      = ld;
        increment_temp_register = inc;
        decrement_temp_register = dec;
        temp_load_value         = val;
        if (ld) begin
            m_temp = val;
        end else if (inc && !dec) begin
            m_temp = m_temp + 8'sd1;
            m_idx  = (m_idx + TBL_LEN - 1) % TBL_LEN;
        end else if (dec && !inc) begin
            m_temp = m_temp - 8'sd1;
            m_idx  = (m_idx + 1) % TBL_LEN;
        end
        temp_sb.push_back('{tag, exp_flags(m_temp), PHASE_TBL[m_idx]});
        tick();
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b0;
        decrement_temp_register = 1'b0;
        e = temp_sb.pop_front();
        check_output({e.tag, "_flags"}, {29'd0, temp_is_positive, temp_is_negative, temp_is_zero},
                     {29'd0, e.flags});
        check_output({e.tag, "_phase"}, {28'd0, stepper_phase}, {28'd0, e.phase});
    endtask

    task automatic pulse_start(input logic [DELAY_W-1:0] val);
        delay_value         = val;
        start_delay_counter = 1'b1;
        tick();
        start_delay_counter = 1'b0;
    endtask

    task automatic start_delay(input logic [DELAY_W-1:0] val, input int exp_edges);
        done_sb.push_back(exp_edges);
        pulse_start(val);
    endtask

    // Edges are counted with the start-sampling edge as edge 1.
    task automatic wait_done(input string tag, input int pause_at, input int pause_len);
        int edges;
        int exp_edges;
        edges     = 1;
        exp_edges = done_sb.pop_front();
        while (!delay_done && edges < WAIT_MAX) begin
            enable_delay_counter = !(edges >= pause_at && edges < pause_at + pause_len);
            tick();
            edges++;
        end
        enable_delay_counter = 1'b1;
        check_output({tag, "_latency"}, edges, exp_edges);
        check_output({tag, "_done"}, {31'd0, delay_done}, 32'd1);
        repeat (5) tick();
        check_output({tag, "_hold"}, {31'd0, delay_done}, 32'd1);
    endtask

    initial begin
        total                   = 0;
        bad                     = 0;
        m_temp                  = 8'sd0;
        m_idx                   = 0;
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b0;
        decrement_temp_register = 1'b0;
        temp_load_value         = 8'sd0;
        start_delay_counter     = 1'b0;
        enable_delay_counter    = 1'b1;
        delay_value             = '0;
        reset_n                 = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) tick();
        check_output("rst_flags", {29'd0, temp_is_positive, temp_is_negative, temp_is_zero}, 32'd1);
        check_output("rst_phase", {28'd0, stepper_phase}, {28'd0, PHASE_TBL[0]});
        check_output("rst_done", {31'd0, delay_done}, 32'd0);
        reset_n = 1'b1;
        tick();

        apply_stimulus("ld5", 1'b1, 1'b0, 1'b0, 8'sd5);
        for (int i = 0; i < 5; i++) apply_stimulus($sformatf("dec%0d", i), 1'b0, 1'b0, 1'b1, 8'sd0);

        apply_stimulus("ld127", 1'b1, 1'b0, 1'b0, 8'sd127);
        apply_stimulus("inc_wrap", 1'b0, 1'b1, 1'b0, 8'sd0);
        apply_stimulus("ldmin", 1'b1, 1'b0, 1'b0, -8'sd128);
        apply_stimulus("dec_wrap", 1'b0, 1'b0, 1'b1, 8'sd0);
        apply_stimulus("ld_all", 1'b1, 1'b1, 1'b1, -8'sd3);
        apply_stimulus("inc_dec_hold", 1'b0, 1'b1, 1'b1, 8'sd77);
        apply_stimulus("inc_m2", 1'b0, 1'b1, 1'b0, 8'sd0);
        apply_stimulus("ldm1", 1'b1, 1'b0, 1'b0, -8'sd1);
        apply_stimulus("inc_zero", 1'b0, 1'b1, 1'b0, 8'sd0);
        apply_stimulus("inc_back", 1'b0, 1'b1, 1'b0, 8'sd0);

        start_delay(8'd3, 3 * PRESCALE + 2);
        wait_done("dly3", 0, 0);

        start_delay(8'd3, 3 * PRESCALE + 2 + 10);
        wait_done("dly3_pause", 5, 10);

        // count reaches 1 after the 8th edge past the sampling edge
        pulse_start(8'd3);
        check_output("restart_clear", {31'd0, delay_done}, 32'd0);
        repeat (8) tick();
        check_output("restart_pre", {31'd0, delay_done}, 32'd0);
        start_delay(8'd3, 3 * PRESCALE + 2);
        wait_done("dly3_restart", 0, 0);

        apply_stimulus("ld9", 1'b1, 1'b0, 1'b0, 8'sd9);
        apply_stimulus("dec_pre_rst", 1'b0, 1'b0, 1'b1, 8'sd0);
        pulse_start(8'd3);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        m_temp = 8'sd0;
        m_idx  = 0;
        check_output("arst_flags", {29'd0, temp_is_positive, temp_is_negative, temp_is_zero}, 32'd1);
        check_output("arst_phase", {28'd0, stepper_phase}, {28'd0, PHASE_TBL[0]});
        check_output("arst_done", {31'd0, delay_done}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check_output("arst_abandon", {31'd0, delay_done}, 32'd0);

        enable_delay_counter = 1'b0;
        start_delay(8'd0, 2);
        wait_done("dly0", 0, WAIT_MAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_delay_unit.md
STEP_DELAY_UNIT -- requirements
Module: step_delay_unit

Interface
REQ-001 Parameter: PRESCALE, default 50000; clk cycles per delay tick (1 ms at 50 MHz); legal range 1 or more.
REQ-002 Parameter: DELAY_W, default 8; width of the delay count.
REQ-003 Port: clk, input, 1, sole clock; all state is rising-edge.
REQ-004 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: load_temp_register / increment_temp_register / decrement_temp_register, input, 1 each, temp register commands.
REQ-006 Port: temp_load_value, input, 8, signed two's-complement load data.
REQ-007 Port: start_delay_counter / enable_delay_counter, input, 1 each, delay start pulse and run enable.
REQ-008 Port: delay_value, input, DELAY_W, delay length in ticks.
REQ-009 Port: temp_is_positive / temp_is_negative / temp_is_zero, output, 1 each, sign status of temp.
REQ-010 Port: delay_done, output, 1, delay-complete status.
REQ-011 Port: stepper_phase, output, 4, motor coil drive pattern.

Function
REQ-012 Temp register: 8-bit signed; command priority is load > increment > decrement; increment and decrement together without load = hold.
REQ-013 Increment/decrement wrap two's-complement (127+1 = -128, -128-1 = 127); no saturation.
REQ-014 Status flags decode the temp register output combinationally, so they are valid the cycle after the update; exactly one flag is high at all times.
REQ-015 The stepper phase index moves one position forward on an effective decrement and one position backward on an effective increment; load does not move it; the index wraps at the table ends.
REQ-016 Delay FSM states: IDLE, COUNT, DONE.
REQ-017 In any state, start_delay_counter loads count = delay_value, clears the prescaler and delay_done, and enters COUNT on the next edge; a start during COUNT restarts the delay.
REQ-018 In COUNT, when enable_delay_counter = 1 and count is nonzero, the prescaler increments; at PRESCALE-1 the prescaler returns to 0 and count decrements.
REQ-019 In COUNT, enable_delay_counter = 0 freezes the prescaler and count.
REQ-020 In COUNT, count == 0 moves the FSM to DONE on the next edge; delay_value = 0 therefore gives DONE two edges after the start pulse, regardless of enable.
REQ-021 delay_done = 1 only in DONE; it is held until the next start or reset; DONE to IDLE never happens autonomously.
REQ-022 Latency: with enable held high, delay_done asserts delay_value*PRESCALE + 2 cycles after the start edge.

Reset
REQ-023 On reset_n low, immediately: temp = 0 (temp_is_zero = 1, others 0), phase index = 0, FSM = IDLE, count = 0, prescaler = 0, delay_done = 0.
REQ-024 Reset mid-delay abandons the delay; delay_done stays 0 until a new start completes.

Configuration
REQ-025 Macro HALF_STEP_EN: when defined, the phase table is 8-entry half-step: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-026 Without HALF_STEP_EN, the table is 4-entry full-step: 1100, 0110, 0011, 1001.
REQ-027 In both builds, stepper_phase after reset = entry 0.

Structure
REQ-028 Shared package step_delay_pkg holds the delay FSM state encoding, both phase tables, the phase-table length constant, and the temp width constant.
REQ-029 The delay FSM, count, and prescaler form sub-module step_delay_timer; the temp register and phase logic stay in the top level.

Verification (bench uses PRESCALE=4)
REQ-030 Load 5, then 5 decrements -> flags go positive to zero; half-step phase walks 1000, 1100, 0100, 0110, 0010, 0011.
REQ-031 Load 127, then increment -> temp = -128 and temp_is_negative = 1; phase moves back one entry.
REQ-032 Load, increment, and decrement in the same cycle with value -3 -> temp = -3 and phase unchanged; increment and decrement together -> hold.
REQ-033 delay_value = 3, start, enable high -> delay_done rises exactly 14 cycles after the start edge and stays high.
REQ-034 delay_value = 3, enable dropped for 10 cycles mid-count -> delay_done is late by exactly 10 cycles; a restart at count 1 reloads to 3.
REQ-035 reset_n low during COUNT -> outputs take reset values asynchronously; delay_value = 0 start afterwards -> delay_done high after 2 edges.
